// File: rtl/hilo_muldiv_seq_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Holds the op encodings, the FSM state encoding and the default datapath width.
package hilo_muldiv_seq_pkg;

    localparam int DATA_W     = 32;
    localparam int ITERATIONS = DATA_W;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/hilo_muldiv_seq_if.sv
// Control-unit <-> multiply/divide sequencer bundle.
//   start, op, a_in, b_in        : request from the control unit
//   busy, done, hilo_we, div_zero : status back to the control unit
//   hi_out, lo_out                : values for the HI and LO registers
// master = control unit side, slave = sequencer side.
interface hilo_muldiv_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic             hilo_we;
    logic             div_zero;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a_in, b_in,
        input  busy, done, hilo_we, div_zero, hi_out, lo_out
    );

    modport slave (
        input  start, op, a_in, b_in,
        output busy, done, hilo_we, div_zero, hi_out, lo_out
    );
endinterface

// File: rtl/hilo_muldiv_seq_div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
//   rem_in       : partial remainder (always < divisor)
//   dividend_bit : next dividend bit shifted into the remainder
//   divisor      : divisor magnitude
//   rem_out      : next partial remainder
//   q_bit        : quotient bit produced by this iteration
module hilo_muldiv_seq_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dividend_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem_in < divisor keeps the shifted value below 2^WIDTH, so the extra
    // top bit of diff is a clean borrow flag.
    assign shifted = {rem_in, dividend_bit};
    assign diff    = shifted - {1'b0, divisor};
    assign q_bit   = ~diff[WIDTH];
    assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/hilo_muldiv_seq.sv
// Multicycle signed MULT/DIV sequencer producing HI/LO for the CPU.
// Fixed 34-cycle latency start->done (1 cycle for divide-by-zero).
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : hilo_muldiv_seq_if slave (start/op/a_in/b_in in; busy/done/
//           hilo_we/div_zero/hi_out/lo_out out)
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one shift-add / restoring-divide iteration per cycle, WIDTH cycles
// FIX   | apply operand signs, load hi_out/lo_out
// DONE  | one-cycle completion (hilo_we or div_zero)
module hilo_muldiv_seq
    import hilo_muldiv_seq_pkg::*;
#(
    parameter int WIDTH = ITERATIONS,
    parameter int CNT_W = 5
) (
    input logic                clk,
    input logic                reset,
    hilo_muldiv_seq_if.slave   bus
);
    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   mag_a_in;
    logic [WIDTH-1:0]   mag_b_in;
    logic [WIDTH-1:0]   mag_b;
    logic               sign_a;
    logic               sign_b;
    logic               op_q;
    logic               dz_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               last_iter;
    logic               dz_req;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   div_rem;
    logic               div_qbit;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    logic busy_c;
    logic done_c;

    // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
    assign mag_a_in  = bus.a_in[WIDTH-1] ? ('0 - bus.a_in) : bus.a_in;
    assign mag_b_in  = bus.b_in[WIDTH-1] ? ('0 - bus.b_in) : bus.b_in;
    assign dz_req    = (bus.op == OP_DIV) && (bus.b_in == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // Multiply: acc = {partial product, remaining multiplier bits}; add the
    // multiplicand into the top half when the current multiplier bit is set,
    // then shift the whole thing right including the carry.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend bits shifting out / quotient bits in}.
    hilo_muldiv_seq_div_step #(
        .WIDTH (WIDTH)
    ) u_div_step (
        .rem_in       (acc[2*WIDTH-1:WIDTH]),
        .dividend_bit (acc[WIDTH-1]),
        .divisor      (mag_b),
        .rem_out      (div_rem),
        .q_bit        (div_qbit)
    );
    assign div_nxt = {div_rem, acc[WIDTH-2:0], div_qbit};

    assign acc_nxt = (op_q == OP_DIV) ? div_nxt : mul_nxt;

    // Remainder follows the dividend sign, giving truncation toward zero.
    assign prod_fix = (sign_a ^ sign_b) ? ('0 - acc) : acc;
    assign quo_fix  = (sign_a ^ sign_b) ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = dz_req ? DONE : RUN;
                end
            end
            RUN: begin
                busy_c = 1'b1;
                if (last_iter) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy_c    = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            acc    <= '0;
            mag_b  <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            op_q   <= OP_MULT;
            dz_q   <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= '0;
                        acc    <= {{WIDTH{1'b0}}, mag_a_in};
                        mag_b  <= mag_b_in;
                        sign_a <= bus.a_in[WIDTH-1];
                        sign_b <= bus.b_in[WIDTH-1];
                        op_q   <= bus.op;
                        dz_q   <= dz_req;
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    if (op_q == OP_DIV) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_c;
    assign bus.done     = done_c;
    assign bus.hilo_we  = done_c & ~dz_q;
    assign bus.div_zero = done_c & dz_q;
    assign bus.hi_out   = hi_q;
    assign bus.lo_out   = lo_q;
endmodule

// File: tb/tb_hilo_muldiv_seq.sv
module tb_hilo_muldiv_seq;
    import hilo_muldiv_seq_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_muldiv_seq_if #(.WIDTH(W)) bus();

    hilo_muldiv_seq #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference result from plain signed arithmetic: {hi, lo}.
    function automatic logic [63:0] model_res(input logic op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == OP_MULT) return 64'(sa * sb);
        if (sb == 0) return 64'(0);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    // Behavioural model: tracks when an accepted request must finish and
    // what HI/LO must hold, cycle by cycle.
    int          edge_cnt = 0;
    bit          m_active = 1'b0;
    bit          m_dz = 1'b0;
    int          m_done_edge = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    bit          cmp_en = 1'b0;

    always @(posedge clk) begin
        bit can_accept;
        edge_cnt++;
        if (reset !== 1'b1) begin
            m_active = 1'b0;
            m_hi = '0;
            m_lo = '0;
        end else begin
            can_accept = !m_active;
            if (m_active && edge_cnt == m_done_edge + 1) m_active = 1'b0;
            if (can_accept && bus.start === 1'b1) begin
                m_active = 1'b1;
                m_dz = (bus.op == OP_DIV) && (bus.b_in == '0);
                m_done_edge = m_dz ? edge_cnt : edge_cnt + 33;
                {p_hi, p_lo} = model_res(bus.op, bus.a_in, bus.b_in);
            end
            if (m_active && edge_cnt == m_done_edge && !m_dz) begin
                m_hi = p_hi;
                m_lo = p_lo;
            end
        end
    end

    always @(negedge clk) begin
        bit e_done;
        if (cmp_en) begin
            e_done = m_active && (edge_cnt == m_done_edge);
            chk("cycle_outputs",
                128'({bus.busy, bus.done, bus.hilo_we, bus.div_zero, bus.hi_out, bus.lo_out}),
                128'({m_active, e_done, e_done && !m_dz, e_done && m_dz, m_hi, m_lo}));
        end
    end

    task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                          input bit dz, input logic [31:0] ehi, input logic [31:0] elo,
                          input string name);
        int i;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clk);
        bus.start = 1'b0;
        i = 1;
        while (bus.done !== 1'b1 && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk({name, "_latency"}, 128'(i), 128'(dz ? 1 : 34));
        chk({name, "_hi"}, 128'(bus.hi_out), 128'(ehi));
        chk({name, "_lo"}, 128'(bus.lo_out), 128'(elo));
        chk({name, "_we"}, 128'(bus.hilo_we), 128'(!dz));
        chk({name, "_dz"}, 128'(bus.div_zero), 128'(dz));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_done, d_at;
        logic [31:0] d_hi, d_lo;

        reset     = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.a_in  = '0;
        bus.b_in  = '0;
        repeat (3) @(negedge clk);
        chk("reset_state",
            128'({bus.busy, bus.done, bus.hilo_we, bus.div_zero, bus.hi_out, bus.lo_out}), 128'(0));
        reset  = 1'b1;
        cmp_en = 1'b1;

        run_op(OP_MULT, 32'd7,        32'd6,        1'b0, 32'h0000_0000, 32'h0000_002A, "mult_7x6");
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5,       1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_m3x5");
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0000_0000, "mult_min_min");
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2,       1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7_2");
        run_op(OP_DIV,  32'd7,        32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, "div_7_m2");
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, "div_min_m1");
        run_op(OP_DIV,  32'd7,        32'd2,        1'b0, 32'h0000_0001, 32'h0000_0003, "div_7_2");
        run_op(OP_DIV,  32'd5,        32'd0,        1'b1, 32'h0000_0001, 32'h0000_0003, "div_by_zero");

        // Reset in the middle of a MULT: abort, clear outputs, no done.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a_in  = 32'd9;
        bus.b_in  = 32'd9;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_outputs",
            128'({bus.busy, bus.done, bus.hilo_we, bus.hi_out, bus.lo_out}), 128'(0));
        reset  = 1'b1;
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (bus.done === 1'b1) n_done++;
            @(negedge clk);
        end
        chk("abort_no_done", 128'(n_done), 128'(0));
        run_op(OP_MULT, 32'd9, 32'd9, 1'b0, 32'h0000_0000, 32'h0000_0051, "mult_after_abort");

        // Start pulsed while busy must be ignored.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.a_in  = 32'd100;
        bus.b_in  = 32'hFFFF_FFFE;
        @(negedge clk);
        n_done = 0;
        d_at   = 0;
        d_hi   = '0;
        d_lo   = '0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                bus.start = 1'b1;
                bus.op    = OP_DIV;
                bus.a_in  = 32'd9;
                bus.b_in  = 32'd0;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                d_at = k;
                d_hi = bus.hi_out;
                d_lo = bus.lo_out;
            end
            @(negedge clk);
        end
        chk("busy_start_done_count", 128'(n_done), 128'(1));
        chk("busy_start_latency", 128'(d_at), 128'(34));
        chk("busy_start_result", 128'({d_hi, d_lo}), 128'(64'hFFFF_FFFF_FFFF_FF38));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
